// File: rtl/alu_issue_seq_pkg.sv
// Shared types and constants for the ALU issue sequencer: opcode map,
// instruction word layout, FSM state encoding and FP classification.
package alu_issue_seq_pkg;

  // Instruction word geometry (45 bits total)
  localparam int INSTR_W  = 45;
  localparam int OPC_MSB  = 44;
  localparam int OPC_LSB  = 41;
  localparam int ADR_MSB  = 40;
  localparam int ADR_LSB  = 35;
  localparam int SEL_BIT  = 34;
  localparam int BSEL_MSB = 33;
  localparam int BSEL_LSB = 32;
  localparam int A_MSB    = 31;
  localparam int A_LSB    = 0;

  localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int ADR_W  = ADR_MSB - ADR_LSB + 1;
  localparam int BSEL_W = BSEL_MSB - BSEL_LSB + 1;
  localparam int A_W    = A_MSB - A_LSB + 1;

  // Gap counter must hold the largest forced gap (7)
  localparam int GAP_W = 3;

  // ALU opcode map; the first three are floating-point operations
  localparam logic [3:0] OP_FADD = 4'b0000;
  localparam logic [3:0] OP_FSUB = 4'b0001;
  localparam logic [3:0] OP_FMUL = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_CMP  = 4'b1101;
  localparam logic [3:0] OP_INC  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // Packed view of the instruction word; field order matches the bit layout above
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADR_W-1:0]  adr;
    logic              sel;
    logic [BSEL_W-1:0] bsel;
    logic [A_W-1:0]    a;
  } instr_t;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // True for opcodes that need idle cycles after issue
  function automatic logic is_fp_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_FADD) || (opc == OP_FSUB) || (opc == OP_FMUL);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Bundle of the instruction input handshake and the ALU-facing outputs.
//
// Handshake: a word moves from master to sequencer on a rising edge where
// in_valid && in_ready are both high. in_valid may not depend on in_ready;
// in_ready is low while the FIFO is full, while flush is high and while reset
// is asserted. alu_valid is a one-cycle strobe; alu_* fields are only
// meaningful when it is high and otherwise hold the previous issue.
interface alu_issue_seq_if;
  import alu_issue_seq_pkg::*;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               flush;
  logic               alu_valid;
  logic [OPC_W-1:0]   alu_opcode;
  logic [ADR_W-1:0]   alu_adr;
  logic               alu_sel;
  logic [BSEL_W-1:0]  alu_bsel;
  logic [A_W-1:0]     alu_A;
  logic               busy;
  logic [15:0]        issue_count;

  modport master (
    output in_valid, in_instr, flush,
    input  in_ready, alu_valid, alu_opcode, alu_adr, alu_sel, alu_bsel,
           alu_A, busy, issue_count
  );

  modport slave (
    input  in_valid, in_instr, flush,
    output in_ready, alu_valid, alu_opcode, alu_adr, alu_sel, alu_bsel,
           alu_A, busy, issue_count
  );

endinterface

// File: rtl/alu_issue_fifo.sv
// Instruction FIFO: DEPTH entries of instr_t, full/empty from an occupancy count.
module alu_issue_fifo
  import alu_issue_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  instr_t push_data,
  input  logic   pop,
  output instr_t head,
  output logic   empty,
  output logic   full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  instr_t        mem_q [DEPTH];
  instr_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next storage, pointers and occupancy; flush drops everything queued
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: queues instruction words and issues one per cycle to
// the ALU, inserting FP_GAP idle cycles after each floating-point operation.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FP_GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_seq_if.slave       bus,
  output state_e               dbg_state
);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  instr_t            out_q, out_d;
  logic [15:0]       cnt_q, cnt_d;

  instr_t            head;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              alu_valid;

  // in_ready is also held low in reset so nothing is accepted then
  assign bus.in_ready = rst_n && !fifo_full && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;

  alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .push      (push),
    .push_data (instr_t'(bus.in_instr)),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next state: pop when issuable, divert into GAP right after an FP issue
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ISSUE: begin
          if ((state_q == ST_ISSUE) && is_fp_op(out_q.opcode) && (FP_GAP > 0)) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(FP_GAP);
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(1)) begin
            gap_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  // Outputs: strobe from state, output fields and issue count load on pop
  always_comb begin
    alu_valid = (state_q == ST_ISSUE);
    out_d     = pop ? head : out_q;
    cnt_d     = pop ? (cnt_q + 16'd1) : cnt_q;
  end

  // Registered ALU fields and issue counter (hold across idle and flush)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.alu_valid   = alu_valid;
  assign bus.alu_opcode  = out_q.opcode;
  assign bus.alu_adr     = out_q.adr;
  assign bus.alu_sel     = out_q.sel;
  assign bus.alu_bsel    = out_q.bsel;
  assign bus.alu_A       = out_q.a;
  assign bus.issue_count = cnt_q;
  assign bus.busy        = !fifo_empty || (state_q == ST_GAP) || alu_valid;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq (DEPTH 4, FP_GAP 2).
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int FP_GAP = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  alu_issue_seq_if bus ();

  alu_issue_seq #(.DEPTH(DEPTH), .FP_GAP(FP_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_total = 0;
  int         n_bad   = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [44:0] mk(input logic [3:0] op, input logic [5:0] adr,
                                     input logic sel, input logic [1:0] bsel,
                                     input logic [31:0] a);
    return {op, adr, sel, bsel, a};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [44:0] w);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
  endtask

  // Run n cycles and return how many had alu_valid high
  task automatic count_valid(input int n, output int v);
    v = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.alu_valid) v++;
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [44:0] w [4];
  int          v;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush    = 1'b0;

    // ---- reset state ----
    rst_n = 1'b0;
    cyc();
    cyc();
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_count", 64'(bus.issue_count), 64'd0);
    check_eq("rst_A", 64'(bus.alu_A), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // ---- single issue latency ----
    drive(mk(4'b0111, 6'd0, 1'b0, 2'd0, 32'd2));
    cyc();                                   // edge 0: accepted
    idle_in();
    check_eq("lat_e0_valid", 64'(bus.alu_valid), 64'd0);
    cyc();                                   // edge 1
    check_eq("lat_e1_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("lat_e1_op", 64'(bus.alu_opcode), 64'h7);
    check_eq("lat_e1_A", 64'(bus.alu_A), 64'd2);
    check_eq("lat_e1_count", 64'(bus.issue_count), 64'd1);
    cyc();                                   // edge 2
    check_eq("lat_e2_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("lat_e2_hold_op", 64'(bus.alu_opcode), 64'h7);
    check_eq("lat_e2_busy", 64'(bus.busy), 64'd0);

    // ---- four non-FP words back to back ----
    w[0] = mk(4'b0111, 6'd5, 1'b1, 2'd3, 32'h1111_1111);
    w[1] = mk(4'b1110, 6'd6, 1'b0, 2'd1, 32'h2222_2222);
    w[2] = mk(4'b0011, 6'd7, 1'b1, 2'd2, 32'h3333_3333);
    w[3] = mk(4'b0100, 6'd8, 1'b0, 2'd0, 32'h4444_4444);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[i][44:41]);
      check_eq("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      drive(w[i]);
      cyc();
      if (i == 0) begin
        check_eq("b2b_first_idle", 64'(bus.alu_valid), 64'd0);
      end else begin
        check_eq("b2b_valid", 64'(bus.alu_valid), 64'd1);
        check_eq("b2b_order", 64'(bus.alu_opcode), 64'(exp_q.pop_front()));
      end
      if (i == 1) begin
        check_eq("b2b_adr", 64'(bus.alu_adr), 64'd5);
        check_eq("b2b_sel", 64'(bus.alu_sel), 64'd1);
        check_eq("b2b_bsel", 64'(bus.alu_bsel), 64'd3);
        check_eq("b2b_A", 64'(bus.alu_A), 64'h1111_1111);
      end
    end
    idle_in();
    cyc();
    check_eq("b2b_last_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("b2b_order", 64'(bus.alu_opcode), 64'(exp_q.pop_front()));
    cyc();
    check_eq("b2b_end_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("b2b_count", 64'(bus.issue_count), 64'd5);

    // ---- FP gap: 0010 then 0011 ----
    drive(mk(4'b0010, 6'd1, 1'b0, 2'd0, 32'hAA));
    cyc();
    drive(mk(4'b0011, 6'd2, 1'b0, 2'd0, 32'hBB));
    cyc();                                   // cycle c
    idle_in();
    check_eq("gap_c_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("gap_c_op", 64'(bus.alu_opcode), 64'h2);
    cyc();                                   // c+1
    check_eq("gap_c1_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("gap_c1_state", 64'(dbg_state), 64'(ST_GAP));
    check_eq("gap_c1_busy", 64'(bus.busy), 64'd1);
    cyc();                                   // c+2
    check_eq("gap_c2_valid", 64'(bus.alu_valid), 64'd0);
    cyc();                                   // c+3
    check_eq("gap_c3_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("gap_c3_op", 64'(bus.alu_opcode), 64'h3);
    cyc();
    check_eq("gap_end_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("gap_count", 64'(bus.issue_count), 64'd7);

    // ---- fill during FP gaps, then flush ----
    drive(mk(4'b0000, 6'd0, 1'b0, 2'd0, 32'hF1));
    cyc();                                   // e0
    drive(mk(4'b0001, 6'd9, 1'b1, 2'd2, 32'hF2));
    cyc();                                   // e1: FADD issued
    check_eq("fill_fadd_op", 64'(bus.alu_opcode), 64'h0);
    drive(mk(4'b0111, 6'd3, 1'b0, 2'd0, 32'h33));
    cyc();                                   // e2
    drive(mk(4'b0111, 6'd4, 1'b0, 2'd0, 32'h44));
    cyc();                                   // e3
    drive(mk(4'b0111, 6'd5, 1'b0, 2'd0, 32'h55));
    cyc();                                   // e4: FSUB issued
    check_eq("fill_fsub_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("fill_fsub_op", 64'(bus.alu_opcode), 64'h1);
    drive(mk(4'b0111, 6'd6, 1'b0, 2'd0, 32'h66));
    cyc();                                   // e5: occupancy 4
    check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("full_state", 64'(dbg_state), 64'(ST_GAP));
    drive(mk(4'b0111, 6'd7, 1'b0, 2'd0, 32'h77));
    cyc();                                   // e6: still full
    check_eq("full_in_ready2", 64'(bus.in_ready), 64'd0);
    check_eq("full_valid", 64'(bus.alu_valid), 64'd0);
    idle_in();
    bus.flush = 1'b1;
    cyc();                                   // e7: flushed
    bus.flush = 1'b0;
    check_eq("flush_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    check_eq("flush_count", 64'(bus.issue_count), 64'd9);
    check_eq("flush_hold_op", 64'(bus.alu_opcode), 64'h1);
    check_eq("flush_hold_A", 64'(bus.alu_A), 64'hF2);
    check_eq("flush_state", 64'(dbg_state), 64'(ST_IDLE));
    count_valid(6, v);
    check_eq("flush_no_issue", 64'(v), 64'd0);

    // ---- word offered together with flush is dropped ----
    bus.flush = 1'b1;
    drive(mk(4'b0111, 6'd1, 1'b0, 2'd0, 32'h99));
    #1;
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    bus.flush = 1'b0;
    idle_in();
    check_eq("flush_drop_busy", 64'(bus.busy), 64'd0);
    count_valid(3, v);
    check_eq("flush_drop_issue", 64'(v), 64'd0);
    check_eq("flush_drop_count", 64'(bus.issue_count), 64'd9);

    // ---- reset mid-gap with three queued words ----
    drive(mk(4'b0010, 6'd1, 1'b0, 2'd0, 32'h10));
    cyc();
    drive(mk(4'b0111, 6'd2, 1'b0, 2'd0, 32'h20));
    cyc();
    drive(mk(4'b0111, 6'd3, 1'b0, 2'd0, 32'h30));
    cyc();
    drive(mk(4'b0111, 6'd4, 1'b0, 2'd0, 32'h40));
    cyc();
    idle_in();
    check_eq("mid_gap_state", 64'(dbg_state), 64'(ST_GAP));
    rst_n = 1'b0;
    cyc();
    check_eq("mrst_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("mrst_op", 64'(bus.alu_opcode), 64'd0);
    check_eq("mrst_A", 64'(bus.alu_A), 64'd0);
    check_eq("mrst_count", 64'(bus.issue_count), 64'd0);
    check_eq("mrst_busy", 64'(bus.busy), 64'd0);
    check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    count_valid(6, v);
    check_eq("mrst_no_issue", 64'(v), 64'd0);
    check_eq("mrst_count_after", 64'(bus.issue_count), 64'd0);

    // ---- issue counter wrap ----
    drive(mk(4'b0111, 6'd0, 1'b0, 2'd0, 32'h5));
    for (int i = 0; i < 65536; i++) cyc();   // 65535 issues so far
    check_eq("wrap_ffff", 64'(bus.issue_count), 64'hFFFF);
    idle_in();
    cyc();                                   // one more issue
    check_eq("wrap_valid", 64'(bus.alu_valid), 64'd1);
    check_eq("wrap_zero", 64'(bus.issue_count), 64'h0);
    cyc();
    check_eq("wrap_end_valid", 64'(bus.alu_valid), 64'd0);
    check_eq("wrap_hold", 64'(bus.issue_count), 64'h0);

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter DEPTH, default 4; instruction FIFO entries, power of two, 2..16.
REQ-002 Parameter FP_GAP, default 2; idle cycles forced after each floating-point issue, 0..7.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  in_instr holds a valid instruction word.
REQ-006 in_instr  input  45  packed word: [44:41] opcode, [40:35] adr, [34] sel, [33:32] bsel, [31:0] A.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 flush  input  1  discard all queued and pending work.
REQ-009 alu_valid  output  1  ALU acts on alu_* fields this cycle; the ALU clock-enable is qualified by it.
REQ-010 alu_opcode  output  4  opcode to ALU.
REQ-011 alu_adr  output  6  memory address to ALU.
REQ-012 alu_sel  output  1  register select to ALU.
REQ-013 alu_bsel  output  2  byte select to ALU.
REQ-014 alu_A  output  32  immediate/operand to ALU.
REQ-015 busy  output  1  FIFO non-empty, or GAP state, or alu_valid high.
REQ-016 issue_count  output  16  number of instructions issued since reset.

Function
REQ-017 Transfer occurs on a rising edge with in_valid && in_ready; the word is written to the FIFO tail.
REQ-018 in_ready SHALL be !full && !flush; no write-through bypass when full, even if a pop occurs in the same cycle.
REQ-019 FSM states: IDLE (nothing issuable), ISSUE (alu_valid high this cycle), GAP (counting down FP_GAP).
REQ-020 From IDLE or ISSUE: if FIFO non-empty and not flush, pop head into the output registers and enter ISSUE; else enter IDLE.
REQ-021 From ISSUE, if the issued opcode is 4'b0000, 4'b0001 or 4'b0010 (FP add/sub/mult) and FP_GAP>0, enter GAP with counter = FP_GAP, and do not pop in that transition.
REQ-022 GAP decrements each cycle; on the cycle the counter reaches 1 the next transition follows REQ-020 rules.
REQ-023 Latency: word accepted at edge k into an empty FIFO in IDLE SHALL show alu_valid high between edges k+1 and k+2.
REQ-024 Non-FP instructions SHALL issue on consecutive cycles with no bubbles while the FIFO is non-empty.
REQ-025 After an FP issue in cycle c, next alu_valid SHALL be no earlier than cycle c+1+FP_GAP.
REQ-026 alu_* fields are registered; while alu_valid is low they hold the last issued values.
REQ-027 issue_count increments by 1 on every alu_valid cycle, wraps 16'hFFFF -> 16'h0000.
REQ-028 flush (synchronous): FIFO emptied, GAP abandoned, state -> IDLE, alu_valid low the next cycle; a word offered with flush is not accepted; issue_count and alu_* fields unchanged.
REQ-029 flush and rst_n low together: reset wins.
REQ-030 FIFO order strictly preserved; pointers wrap modulo DEPTH, full/empty resolved by an occupancy count 0..DEPTH.

Reset
REQ-031 On rst_n low at a rising edge: FIFO empty, state IDLE, GAP counter 0, alu_valid 0, all alu_* fields 0, issue_count 0, busy 0.
REQ-032 in_ready SHALL be 0 during reset cycles and 1 in the first cycle after rst_n returns high.
REQ-033 Reset mid-GAP or with a non-empty FIFO discards all pending words; none issue afterwards.

Structure
REQ-034 Shared package holds the opcode constants (16 ALU opcodes), the field bit positions of the 45-bit word, and an is_fp_op classification function.
REQ-035 One sub-module, alu_issue_fifo (DEPTH x 45, occupancy count, push/pop/flush); FSM, gap counter and output registers stay in alu_issue_seq.

Verification
REQ-036 Reset, then push opcode 0111, adr 0, A 2 at edge 0 -> alu_valid high only between edges 1 and 2, alu_opcode 0111, alu_A 2, issue_count 1.
REQ-037 Push four non-FP words back-to-back (0111, 1110, 0011, 0100) -> four consecutive alu_valid cycles, same order, in_ready low while occupancy is 4.
REQ-038 Push 0010 then 0011 with FP_GAP 2 -> alu_valid for 0010 in cycle c, low in c+1 and c+2, 0011 issued in c+3.
REQ-039 Fill FIFO to 4 during an FP gap, assert flush for 1 cycle -> no further alu_valid, busy 0 the cycle after, issue_count unchanged, fields hold last values.
REQ-040 Preload issue_count to 16'hFFFF via 65535 issues, issue one more -> issue_count 16'h0000.
REQ-041 Drop rst_n mid-GAP with 3 queued words -> all outputs 0 next cycle, no later issue of the queued words.
